// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority voting, false-start rejection,
// parity/framing/break/overrun detection and a one-entry valid/ready holding register.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned UART_BPS  = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       break_det,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF    = BPS_CNT / 2;
    localparam int unsigned CW      = $clog2(BPS_CNT);

    localparam logic [CW-1:0] C_SMP0 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_SMP1 = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_END  = CW'(BPS_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_rxd_s1;
    logic                 r_rxd_s2;
    logic                 r_rxd_d;
    logic [CW-1:0]        r_clk_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_smp0;
    logic                 r_smp1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_f;
    logic                 r_ferr_acc;

    logic       w_maj;
    logic       w_dec;
    logic       w_end;
    logic       w_fall;
    logic       w_last_stop;
    logic       w_frame_ferr;
    logic       w_frame_brk;
    logic       w_accept;
    logic [7:0] w_data_ext;

    always_comb begin
        w_maj        = (r_smp0 & r_smp1) | (r_smp0 & r_rxd_s2) | (r_smp1 & r_rxd_s2);
        w_dec        = (r_clk_cnt == C_DEC);
        w_end        = (r_clk_cnt == C_END);
        w_fall       = r_rxd_d & ~r_rxd_s2;
        w_last_stop  = (r_state == S_STOP) && w_dec && (r_bit_cnt == 4'(STOP_BITS - 1));
        w_frame_ferr = r_ferr_acc | ~w_maj;
        w_frame_brk  = (r_shift == '0) && w_frame_ferr;
        w_accept     = rx_valid && rx_ready;
        w_data_ext   = '0;
        w_data_ext[DATA_BITS-1:0] = r_shift;
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_d    <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
            r_shift    <= '0;
            r_perr_f   <= 1'b0;
            r_ferr_acc <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_rxd_s1  <= uart_rxd;
            r_rxd_s2  <= r_rxd_s1;
            r_rxd_d   <= r_rxd_s2;
            break_det <= 1'b0;
            overrun   <= 1'b0;

            if (w_accept)
                rx_valid <= 1'b0;

            if (r_state == S_IDLE)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= w_end ? '0 : r_clk_cnt + 1'b1;

            if (r_clk_cnt == C_SMP0)
                r_smp0 <= r_rxd_s2;
            if (r_clk_cnt == C_SMP1)
                r_smp1 <= r_rxd_s2;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_START;
                        r_bit_cnt  <= '0;
                        r_perr_f   <= 1'b0;
                        r_ferr_acc <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_maj)
                        r_state <= S_IDLE;
                    else if (w_end)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_dec)
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_end) begin
                        if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_dec)
                        r_perr_f <= (PARITY == 1) ? ~(^r_shift ^ w_maj) : (^r_shift ^ w_maj);
                    if (w_end)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    // The final stop bit ends the frame at its decision point, not at bit end.
                    if (w_last_stop)
                        r_state <= S_IDLE;
                    else if (w_dec)
                        r_ferr_acc <= r_ferr_acc | ~w_maj;
                    else if (w_end)
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_last_stop) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= w_data_ext;
                    rx_perr  <= r_perr_f;
                    rx_ferr  <= w_frame_ferr;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                break_det <= w_frame_brk;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 8E1, 7N2) at BPS_CNT = 10,
// directed frames push expected results; a negedge monitor pops on every accepted frame.
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned UART_BPS = 100000;
    localparam int BPS = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [2:0] rxd;
    logic [2:0] ready;
    logic [7:0] data_o  [3];
    logic       valid_o [3];
    logic       perr_o  [3];
    logic       ferr_o  [3];
    logic       brk_o   [3];
    logic       ovr_o   [3];
    logic       busy_o  [3];

    exp_t exp_q [3][$];
    logic prev_valid [3];
    logic brk_rise   [3];
    int   brk_cnt    [3];
    int   ovr_cnt    [3];
    int   errors;
    int   checks;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) u_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[0]),
        .rx_data(data_o[0]), .rx_valid(valid_o[0]), .rx_ready(ready[0]),
        .rx_perr(perr_o[0]), .rx_ferr(ferr_o[0]), .break_det(brk_o[0]),
        .overrun(ovr_o[0]), .busy(busy_o[0]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1)) u_p (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[1]),
        .rx_data(data_o[1]), .rx_valid(valid_o[1]), .rx_ready(ready[1]),
        .rx_perr(perr_o[1]), .rx_ferr(ferr_o[1]), .break_det(brk_o[1]),
        .overrun(ovr_o[1]), .busy(busy_o[1]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7),
                    .PARITY(0), .STOP_BITS(2)) u_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[2]),
        .rx_data(data_o[2]), .rx_valid(valid_o[2]), .rx_ready(ready[2]),
        .rx_perr(perr_o[2]), .rx_ferr(ferr_o[2]), .break_det(brk_o[2]),
        .overrun(ovr_o[2]), .busy(busy_o[2]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f, input logic b);
        return {d, p, f, b};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge sys_clk);
        #1;
    endtask

    // bits[0] is sent first (start bit); gbit selects a bit that gets a one-clock low glitch
    task automatic tx(input int k, input logic [15:0] bits, input int n, input int gbit);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BPS; c++) begin
                rxd[k] = (i == gbit && c == 5) ? 1'b0 : bits[i];
                tick(1);
            end
        end
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        chk("drain", exp_q[k].size(), 0);
    endtask

    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_o[k] && !prev_valid[k])
                brk_rise[k] = brk_o[k];
            if (brk_o[k])
                brk_cnt[k]++;
            if (ovr_o[k])
                ovr_cnt[k]++;
            if (valid_o[k] && ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame inst %0d: got data %0h, expected no frame", k, data_o[k]);
                end else begin
                    exp_t e;
                    e = exp_q[k].pop_front();
                    chk("rx_data", data_o[k], e.data);
                    chk("rx_perr", perr_o[k], e.perr);
                    chk("rx_ferr", ferr_o[k], e.ferr);
                    chk("break_at_valid", brk_rise[k], e.brk);
                end
            end
            prev_valid[k] = valid_o[k];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        for (int k = 0; k < 3; k++) begin
            prev_valid[k] = 1'b0;
            brk_rise[k]   = 1'b0;
            brk_cnt[k]    = 0;
            ovr_cnt[k]    = 0;
        end
        rxd       = '1;
        ready     = '1;
        sys_rst_n = 1'b0;
        tick(3);
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", valid_o[k], 0);
            chk("rst_busy", busy_o[k], 0);
            chk("rst_data", data_o[k], 0);
            chk("rst_flags", {perr_o[k], ferr_o[k], brk_o[k], ovr_o[k]}, 0);
        end
        sys_rst_n = 1'b1;
        tick(5);
        chk("idle_busy", busy_o[0], 0);

        // back-to-back 8N1 frames
        exp_q[0].push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        exp_q[0].push_back(mk(8'hA3, 1'b0, 1'b0, 1'b0));
        tx(0, {1'b1, 8'h55, 1'b0}, 10, -1);
        tx(0, {1'b1, 8'hA3, 1'b0}, 10, -1);
        wait_drain(0);

        // even parity: 0x07 has odd weight, so parity bit 0 is an error and 1 is clean
        exp_q[1].push_back(mk(8'h07, 1'b1, 1'b0, 1'b0));
        exp_q[1].push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
        tx(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
        tx(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);
        wait_drain(1);

        // false start: low for 3 clocks
        tick(10);
        rxd[0] = 1'b0;
        tick(3);
        rxd[0] = 1'b1;
        chk("fs_busy_hi", busy_o[0], 1);
        begin
            int n;
            n = 0;
            while (busy_o[0] && n < 12) begin
                tick(1);
                n++;
            end
            chk("fs_busy_lo", busy_o[0], 0);
            chk("fs_within_10", (n <= 10) ? 1 : 0, 1);
        end
        tick(20);
        chk("fs_no_valid", valid_o[0], 0);

        // overrun: holding register full while a second frame completes
        ready[0] = 1'b0;
        exp_q[0].push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
        tx(0, {1'b1, 8'h11, 1'b0}, 10, -1);
        tx(0, {1'b1, 8'h22, 1'b0}, 10, -1);
        tick(5);
        chk("ovr_valid_held", valid_o[0], 1);
        chk("ovr_data_held", data_o[0], 8'h11);
        chk("ovr_pulses", ovr_cnt[0], 1);
        ready[0] = 1'b1;
        tick(2);
        chk("ovr_valid_fall", valid_o[0], 0);
        wait_drain(0);

        // 7N2 break: data 0, second stop bit low
        exp_q[2].push_back(mk(8'h00, 1'b0, 1'b1, 1'b1));
        tx(2, {1'b0, 1'b1, 7'h00, 1'b0}, 10, -1);
        rxd[2] = 1'b1;
        tick(20);
        chk("brk_pulses", brk_cnt[2], 1);
        exp_q[2].push_back(mk(8'h7F, 1'b0, 1'b0, 1'b0));
        tx(2, {2'b11, 7'h7F, 1'b0}, 10, -1);
        wait_drain(2);

        // reset at data bit 4 of 0x5A, then a clean 0x3C
        tx(0, {1'b1, 8'h5A, 1'b0}, 5, -1);
        rxd[0] = 1'b1;
        tick(3);
        sys_rst_n = 1'b0;
        tick(2);
        chk("mid_rst_busy", busy_o[0], 0);
        chk("mid_rst_valid", valid_o[0], 0);
        sys_rst_n = 1'b1;
        tick(20);
        chk("post_rst_busy", busy_o[0], 0);
        exp_q[0].push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
        tx(0, {1'b1, 8'h3C, 1'b0}, 10, -1);
        wait_drain(0);

        // one-clock glitch mid data bit 2
        exp_q[0].push_back(mk(8'hFF, 1'b0, 1'b0, 1'b0));
        tx(0, {1'b1, 8'hFF, 1'b0}, 10, 3);
        wait_drain(0);
        tick(10);

        chk("ovr_total_a", ovr_cnt[0], 1);
        chk("ovr_total_p", ovr_cnt[1], 0);
        chk("ovr_total_b", ovr_cnt[2], 0);
        chk("brk_total_a", brk_cnt[0], 0);
        chk("brk_total_p", brk_cnt[1], 0);
        chk("brk_total_b", brk_cnt[2], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
